mmu: RTL and testbench
======================

MMU -- requirements
Module: mmu

Interface
REQ-001 Parameter SIZE, default 2: array dimension; all matrices are SIZE x SIZE.
REQ-002 clk  input  1: single clock; all state changes on rising edge.
REQ-003 rst_n  input  1: reset; one clock; reset is asynchronous and active-low.
REQ-004 new_weight_in  input  8 x SIZE x SIZE: weight matrix, unsigned; [k][j] = row k, column j.
REQ-005 new_weight_push  input  1: enqueue new_weight_in into the weight FIFO.
REQ-006 new_weight_rdy  output  1: weight FIFO not full.
REQ-007 data_in  input  8 x SIZE x SIZE: data matrix, unsigned; [i][k].
REQ-008 data_in_push  input  1: enqueue data_in into the data FIFO.
REQ-009 data_in_rdy  output  1: data FIFO not full.
REQ-010 acc_out  output  32 x SIZE x SIZE: head entry of the result FIFO; [i][j].
REQ-011 acc_out_pop  input  1: dequeue the result FIFO head.
REQ-012 acc_out_rdy  output  1: result FIFO not empty.
REQ-013 weight_ld_start  input  1: request to load the next FIFO weight matrix into the array.
REQ-014 weight_ld_rdy  output  1: a weight load may start.
REQ-015 mult_run  input  1: request one matrix multiply.
REQ-016 mult_rdy  output  1: a multiply may start.

Function
REQ-017 Weight, data and result FIFOs SHALL each hold 2 whole matrices.
REQ-018 A push or pop SHALL take effect on the clock edge where it is sampled high with its rdy high; when rdy is low it SHALL be ignored with no state change.
REQ-019 A simultaneous push and pop on a full or empty FIFO SHALL follow REQ-018: a push to a full FIFO is dropped; a pop from an empty FIFO is ignored.
REQ-020 Each FIFO SHALL preserve FIFO order, and pointers SHALL wrap modulo depth.
REQ-021 Control FSM states: IDLE, LOAD, MULT.
REQ-022 weight_ld_rdy SHALL equal (state==IDLE and weight FIFO not empty), combinationally.
REQ-023 mult_rdy SHALL equal (state==IDLE and weights_valid and data FIFO not empty and result FIFO not full), combinationally.
REQ-024 IDLE->LOAD on weight_ld_start with weight_ld_rdy; the FIFO head weight matrix SHALL be popped on that edge.
REQ-025 LOAD SHALL shift one weight row per cycle into the array over SIZE cycles, then return to IDLE and set weights_valid.
REQ-026 IDLE->MULT on mult_run with mult_rdy, only if weight_ld_start is not also accepted; weight load SHALL take priority when both are requested.
REQ-027 On entry to MULT, the data FIFO head SHALL be popped.
REQ-028 MULT SHALL last exactly 2*SIZE cycles, then push the result into the result FIFO and return to IDLE.
REQ-029 Result: acc_out[i][j] = sum over k of data[i][k]*weight[k][j], unsigned 8x8 products, zero-extended, 32-bit accumulate, no saturation.
REQ-030 Requests arriving while not IDLE SHALL be ignored; weights SHALL stay unchanged outside LOAD.
REQ-031 FIFO pushes and pops by the external interface SHALL be honoured in every FSM state.

Reset
REQ-032 On rst_n low, all FIFOs SHALL empty, state SHALL go to IDLE, weights_valid SHALL clear, and weight registers and the accumulator SHALL go to 0.
REQ-033 During reset, new_weight_rdy=1, data_in_rdy=1, acc_out_rdy=0, weight_ld_rdy=0, mult_rdy=0, and acc_out=0.
REQ-034 Reset asserted mid-LOAD or mid-MULT SHALL abort the operation, with no partial result pushed.

Verification
REQ-035 Reset, then one cycle later -> new_weight_rdy=1, weight_ld_rdy=0, mult_rdy=0, acc_out_rdy=0.
REQ-036 Push weights {{11h,12h},{21h,22h}} for one cycle -> weight_ld_rdy=1 on the next cycle; pulse weight_ld_start -> weight_ld_rdy=0 for SIZE cycles, then 0, since the FIFO is empty.
REQ-037 With weights {{1,2},{3,4}} loaded, push data {{1,0},{0,1}} and pulse mult_run -> after 2*SIZE cycles acc_out_rdy=1 and acc_out={{1,2},{3,4}}; pop -> acc_out_rdy=0.
REQ-038 Weights all FFh and data all FFh -> every acc_out element = 1FC02h (2*FE01h).
REQ-039 Push 3 weight matrices back-to-back -> new_weight_rdy=0 after the 2nd push, and the 3rd is dropped; two loads then consume the 1st and 2nd matrices in order.
REQ-040 Fill the result FIFO with 2 results -> mult_rdy=0 with data pending; one pop -> mult_rdy=1; weight_ld_start and mult_run asserted in the same cycle -> LOAD is entered.

Source files
------------

// File: rtl/mmu.sv
// Matrix multiply unit. Weight, data and result matrices are buffered in
// two-entry FIFOs. A small IDLE/LOAD/MULT controller moves weights into the
// array and runs one multiply at a time. Each acc_out element is the unsigned
// dot product of a data row with a weight column.
module mmu #(
  parameter int SIZE = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]   new_weight_in,
  input  logic                             new_weight_push,
  output logic                             new_weight_rdy,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]   data_in,
  input  logic                             data_in_push,
  output logic                             data_in_rdy,
  output logic [SIZE-1:0][SIZE-1:0][31:0]  acc_out,
  input  logic                             acc_out_pop,
  output logic                             acc_out_rdy,
  input  logic                             weight_ld_start,
  output logic                             weight_ld_rdy,
  input  logic                             mult_run,
  output logic                             mult_rdy
);

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(2 * SIZE);
  localparam int KW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(2 * SIZE - 1);
  localparam logic [CNT_W-1:0] K_END     = CNT_W'(SIZE);

  typedef logic [SIZE-1:0][SIZE-1:0][7:0]  mat8_t;
  typedef logic [SIZE-1:0][SIZE-1:0][31:0] mat32_t;
  typedef enum logic [1:0] {IDLE, LOAD, MULT} state_e;

  // Unsigned 8x8 product, zero-extended and added into a 32-bit sum (wraps).
  function automatic logic [31:0] mac(input logic [31:0] acc,
                                      input logic [7:0]  a,
                                      input logic [7:0]  b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    return acc + {16'd0, p};
  endfunction

  // FIFO storage; DEPTH is 2, so one-bit pointers wrap naturally.
  mat8_t       wmem_q [DEPTH];
  logic        wwr_q, wrd_q;
  logic [1:0]  wcnt_q;
  mat8_t       dmem_q [DEPTH];
  logic        dwr_q, drd_q;
  logic [1:0]  dcnt_q;
  mat32_t      rmem_q [DEPTH];
  logic        rwr_q, rrd_q;
  logic [1:0]  rcnt_q;

  // Array state. lbuf_q/dbuf_q hold the popped operand, so later pushes can
  // reuse the freed FIFO slot while the operation is still running.
  mat8_t            lbuf_q, dbuf_q, w_q;
  mat32_t           acc_q;
  logic             wvalid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [KW-1:0]    k_idx;
  state_e           state_q, state_d;

  logic w_push, w_pop, d_push, d_pop, r_push, r_pop;
  logic ld_go, mult_go, load_done, mult_done;

  assign new_weight_rdy = (wcnt_q != 2'd2);
  assign data_in_rdy    = (dcnt_q != 2'd2);
  assign acc_out_rdy    = (rcnt_q != 2'd0);
  assign acc_out        = rmem_q[rrd_q];
  assign k_idx          = cnt_q[KW-1:0];

  assign w_push = new_weight_push && new_weight_rdy;
  assign w_pop  = ld_go;
  assign d_push = data_in_push && data_in_rdy;
  assign d_pop  = mult_go;
  assign r_push = mult_done && (rcnt_q != 2'd2);
  assign r_pop  = acc_out_pop && acc_out_rdy;

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a weight load wins over a multiply requested together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_go) state_d = LOAD;
               else if (mult_go) state_d = MULT;
      LOAD:    if (load_done) state_d = IDLE;
      MULT:    if (mult_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs: handshake readies and operation strobes.
  always_comb begin
    weight_ld_rdy = (state_q == IDLE) && (wcnt_q != 2'd0);
    mult_rdy      = (state_q == IDLE) && wvalid_q && (dcnt_q != 2'd0) && (rcnt_q != 2'd2);
    ld_go         = weight_ld_start && weight_ld_rdy;
    mult_go       = mult_run && mult_rdy && !ld_go;
    load_done     = (state_q == LOAD) && (cnt_q == LOAD_LAST);
    mult_done     = (state_q == MULT) && (cnt_q == MULT_LAST);
  end

  // Weight FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wwr_q  <= 1'b0;
      wrd_q  <= 1'b0;
      wcnt_q <= 2'd0;
      for (int n = 0; n < DEPTH; n++) wmem_q[n] <= '0;
    end else begin
      if (w_push) begin
        wmem_q[wwr_q] <= new_weight_in;
        wwr_q         <= wwr_q + 1'b1;
      end
      if (w_pop) wrd_q <= wrd_q + 1'b1;
      if (w_push && !w_pop)      wcnt_q <= wcnt_q + 2'd1;
      else if (!w_push && w_pop) wcnt_q <= wcnt_q - 2'd1;
    end
  end

  // Data FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwr_q  <= 1'b0;
      drd_q  <= 1'b0;
      dcnt_q <= 2'd0;
      for (int n = 0; n < DEPTH; n++) dmem_q[n] <= '0;
    end else begin
      if (d_push) begin
        dmem_q[dwr_q] <= data_in;
        dwr_q         <= dwr_q + 1'b1;
      end
      if (d_pop) drd_q <= drd_q + 1'b1;
      if (d_push && !d_pop)      dcnt_q <= dcnt_q + 2'd1;
      else if (!d_push && d_pop) dcnt_q <= dcnt_q - 2'd1;
    end
  end

  // Result FIFO; storage is cleared so acc_out reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rwr_q  <= 1'b0;
      rrd_q  <= 1'b0;
      rcnt_q <= 2'd0;
      for (int n = 0; n < DEPTH; n++) rmem_q[n] <= '0;
    end else begin
      if (r_push) begin
        rmem_q[rwr_q] <= acc_q;
        rwr_q         <= rwr_q + 1'b1;
      end
      if (r_pop) rrd_q <= rrd_q + 1'b1;
      if (r_push && !r_pop)      rcnt_q <= rcnt_q + 2'd1;
      else if (!r_push && r_pop) rcnt_q <= rcnt_q - 2'd1;
    end
  end

  // Operation cycle counter, restarted on every LOAD/MULT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt_q <= '0;
    else if (ld_go || mult_go)            cnt_q <= '0;
    else if (load_done || mult_done)      cnt_q <= '0;
    else if (state_q != IDLE)             cnt_q <= cnt_q + 1'b1;
  end

  // Weight load: capture the FIFO head, then shift one row per cycle so that
  // after SIZE cycles row k of the array holds row k of the matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbuf_q   <= '0;
      w_q      <= '0;
      wvalid_q <= 1'b0;
    end else begin
      if (ld_go) lbuf_q <= wmem_q[wrd_q];
      if (state_q == LOAD) begin
        for (int k = 0; k < SIZE - 1; k++) w_q[k] <= w_q[k+1];
        w_q[SIZE-1] <= lbuf_q[k_idx];
        if (load_done) wvalid_q <= 1'b1;
      end
    end
  end

  // Multiply: one k term per cycle for the first SIZE cycles; the remaining
  // cycles keep the fixed 2*SIZE latency before the result is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbuf_q <= '0;
      acc_q  <= '0;
    end else if (mult_go) begin
      dbuf_q <= dmem_q[drd_q];
      acc_q  <= '0;
    end else if ((state_q == MULT) && (cnt_q < K_END)) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          acc_q[i][j] <= mac(acc_q[i][j], dbuf_q[i][k_idx], w_q[k_idx][j]);
    end
  end

endmodule

// File: tb/tb_mmu.sv
// Bench for mmu: directed scenarios plus a randomized phase, every cycle
// checked against a queue-based matrix model of the unit.
module tb_mmu;
  localparam int S = 2;
  typedef logic [S-1:0][S-1:0][7:0]  m8_t;
  typedef logic [S-1:0][S-1:0][31:0] m32_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  m8_t  new_weight_in = '0;
  logic new_weight_push = 1'b0;
  logic new_weight_rdy;
  m8_t  data_in = '0;
  logic data_in_push = 1'b0;
  logic data_in_rdy;
  m32_t acc_out;
  logic acc_out_pop = 1'b0;
  logic acc_out_rdy;
  logic weight_ld_start = 1'b0;
  logic weight_ld_rdy;
  logic mult_run = 1'b0;
  logic mult_rdy;

  mmu #(.SIZE(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .new_weight_in(new_weight_in), .new_weight_push(new_weight_push),
    .new_weight_rdy(new_weight_rdy),
    .data_in(data_in), .data_in_push(data_in_push), .data_in_rdy(data_in_rdy),
    .acc_out(acc_out), .acc_out_pop(acc_out_pop), .acc_out_rdy(acc_out_rdy),
    .weight_ld_start(weight_ld_start), .weight_ld_rdy(weight_ld_rdy),
    .mult_run(mult_run), .mult_rdy(mult_rdy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model state: FIFO contents as queues, busy mode with remaining cycles.
  m8_t  wq[$];
  m8_t  dq[$];
  m32_t rq[$];
  int   mode = 0;   // 0 idle, 1 loading, 2 multiplying
  int   rem  = 0;
  m8_t  wts  = '0;
  m8_t  pend = '0;
  bit   wvalid = 1'b0;
  m32_t pres = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic m8_t mk(input logic [7:0] a, b, c, d);
    m8_t m;
    m[0][0] = a; m[0][1] = b; m[1][0] = c; m[1][1] = d;
    return m;
  endfunction

  function automatic m8_t rand_mat();
    m8_t m;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        m[i][j] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    return m;
  endfunction

  function automatic m32_t matmul(input m8_t d, input m8_t w);
    m32_t r;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        r[i][j] = 32'd0;
        for (int k = 0; k < S; k++) r[i][j] += 32'(d[i][k]) * 32'(w[k][j]);
      end
    return r;
  endfunction

  function automatic m32_t widen(input m8_t m);
    m32_t r;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) r[i][j] = 32'(m[i][j]);
    return r;
  endfunction

  task automatic chk_mat(input string tag, input m32_t exp);
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j), 64'(acc_out[i][j]), 64'(exp[i][j]));
  endtask

  // One clock: compare DUT against the model before the edge, advance both.
  task automatic tick();
    bit ldrdy, mrdy, do_wp, do_dp, do_ap, do_ld, do_mu;
    m8_t nw, nd, tmp;
    m32_t rtmp;
    ldrdy = (mode == 0) && (wq.size() > 0);
    mrdy  = (mode == 0) && wvalid && (dq.size() > 0) && (rq.size() < 2);
    chk("new_weight_rdy", 64'(new_weight_rdy), 64'(wq.size() < 2));
    chk("data_in_rdy", 64'(data_in_rdy), 64'(dq.size() < 2));
    chk("acc_out_rdy", 64'(acc_out_rdy), 64'(rq.size() > 0));
    chk("weight_ld_rdy", 64'(weight_ld_rdy), 64'(ldrdy));
    chk("mult_rdy", 64'(mult_rdy), 64'(mrdy));
    if (rq.size() > 0) chk_mat("acc_out", rq[0]);
    do_wp = new_weight_push && (wq.size() < 2);
    do_dp = data_in_push && (dq.size() < 2);
    do_ap = acc_out_pop && (rq.size() > 0);
    do_ld = weight_ld_start && ldrdy;
    do_mu = mult_run && mrdy && !do_ld;
    nw = new_weight_in;
    nd = data_in;
    @(posedge clk);
    #1;
    if (do_ap) rtmp = rq.pop_front();
    if (do_ld) pend = wq.pop_front();
    if (do_mu) begin
      tmp  = dq.pop_front();
      pres = matmul(tmp, wts);
    end
    if (do_wp) wq.push_back(nw);
    if (do_dp) dq.push_back(nd);
    if (mode == 1) begin
      rem--;
      if (rem == 0) begin wts = pend; wvalid = 1'b1; mode = 0; end
    end else if (mode == 2) begin
      rem--;
      if (rem == 0) begin rq.push_back(pres); mode = 0; end
    end
    if (do_ld) begin mode = 1; rem = S; end
    if (do_mu) begin mode = 2; rem = 2 * S; end
    new_weight_push = 1'b0;
    data_in_push    = 1'b0;
    acc_out_pop     = 1'b0;
    weight_ld_start = 1'b0;
    mult_run        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic push_w(input m8_t m);
    new_weight_in = m; new_weight_push = 1'b1; tick();
  endtask

  task automatic push_d(input m8_t m);
    data_in = m; data_in_push = 1'b1; tick();
  endtask

  task automatic do_load();
    weight_ld_start = 1'b1; tick(); idle(S);
  endtask

  task automatic do_mult(input m8_t d);
    push_d(d); mult_run = 1'b1; tick(); idle(2 * S);
  endtask

  task automatic pop_r();
    acc_out_pop = 1'b1; tick();
  endtask

  // Asynchronous reset mid-cycle; outputs are checked while it is held.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_new_weight_rdy", 64'(new_weight_rdy), 64'd1);
    chk("rst_data_in_rdy", 64'(data_in_rdy), 64'd1);
    chk("rst_acc_out_rdy", 64'(acc_out_rdy), 64'd0);
    chk("rst_weight_ld_rdy", 64'(weight_ld_rdy), 64'd0);
    chk("rst_mult_rdy", 64'(mult_rdy), 64'd0);
    chk_mat("rst_acc_out", '0);
    wq.delete(); dq.delete(); rq.delete();
    mode = 0; rem = 0; wvalid = 1'b0; wts = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  m8_t ident, ma, mb, mc;
  m32_t e;

  initial begin
    ident = mk(8'd1, 8'd0, 8'd0, 8'd1);
    #3;
    do_reset();
    tick();

    // Single weight push, then load drains the FIFO.
    push_w(mk(8'h11, 8'h12, 8'h21, 8'h22));
    chk("ld_rdy_after_push", 64'(weight_ld_rdy), 64'd1);
    weight_ld_start = 1'b1;
    tick();
    for (int c = 0; c < S; c++) begin
      chk("ld_rdy_during_load", 64'(weight_ld_rdy), 64'd0);
      tick();
    end
    chk("ld_rdy_fifo_empty", 64'(weight_ld_rdy), 64'd0);

    // Identity data reproduces the weights.
    push_w(mk(8'd1, 8'd2, 8'd3, 8'd4));
    do_load();
    push_d(ident);
    mult_run = 1'b1;
    tick();
    idle(2 * S - 1);
    chk("acc_rdy_early", 64'(acc_out_rdy), 64'd0);
    tick();
    chk("acc_rdy_done", 64'(acc_out_rdy), 64'd1);
    e = '0; e[0][0] = 1; e[0][1] = 2; e[1][0] = 3; e[1][1] = 4;
    chk_mat("ident_result", e);
    pop_r();
    chk("acc_rdy_popped", 64'(acc_out_rdy), 64'd0);

    // Largest operands.
    push_w(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
    do_load();
    do_mult(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) e[i][j] = 32'h1FC02;
    chk_mat("max_result", e);
    pop_r();

    // Three pushes: the third is dropped, loads keep order.
    ma = mk(8'd5, 8'd6, 8'd7, 8'd8);
    mb = mk(8'd9, 8'd10, 8'd11, 8'd12);
    mc = mk(8'd13, 8'd14, 8'd15, 8'd16);
    push_w(ma);
    push_w(mb);
    chk("w_full_after_2", 64'(new_weight_rdy), 64'd0);
    push_w(mc);
    do_load();
    do_mult(ident);
    chk_mat("order_first", widen(ma));
    pop_r();
    do_load();
    do_mult(ident);
    chk_mat("order_second", widen(mb));
    pop_r();
    chk("third_dropped", 64'(weight_ld_rdy), 64'd0);

    // Full result FIFO stalls multiplies; load wins a simultaneous request.
    do_mult(ident);
    do_mult(ident);
    push_d(ident);
    chk("mult_rdy_res_full", 64'(mult_rdy), 64'd0);
    pop_r();
    chk("mult_rdy_after_pop", 64'(mult_rdy), 64'd1);
    push_w(ma);
    weight_ld_start = 1'b1;
    mult_run = 1'b1;
    tick();
    chk("both_req_ld_busy", 64'(weight_ld_rdy), 64'd0);
    chk("both_req_mult_busy", 64'(mult_rdy), 64'd0);
    idle(S);
    chk("both_req_data_kept", 64'(mult_rdy), 64'd1);
    pop_r();

    // Reset in the middle of a multiply leaves no result behind.
    mult_run = 1'b1;
    tick();
    tick();
    do_reset();
    tick();
    chk("abort_no_result", 64'(acc_out_rdy), 64'd0);
    chk("abort_wvalid_clear", 64'(mult_rdy), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      new_weight_in   = rand_mat();
      data_in         = rand_mat();
      new_weight_push = ($urandom_range(0, 99) < 25);
      data_in_push    = ($urandom_range(0, 99) < 35);
      acc_out_pop     = ($urandom_range(0, 99) < 30);
      weight_ld_start = ($urandom_range(0, 99) < 12);
      mult_run        = ($urandom_range(0, 99) < 45);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
